// File: rtl/alu_pkg.sv
// Shared types and sizing helpers for the multi-cycle ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_CMP = 3'd5,
    OP_MUL = 3'd6,
    OP_DIV = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  typedef struct packed {
    logic carry;
    logic neg;
    logic zero;
    logic div_by_zero;
    logic gt;
    logic eq;
    logic lt;
  } alu_flags_t;

  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/alu_seq_iter_muldiv.sv
// Shared shift/accumulate datapath: shift-add multiply and restoring divide,
// one step per cycle for WIDTH cycles. {hi, lo} ends as product or {rem, quot}.
module iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               clear,
  input  logic               start,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] hilo_nxt
);

  localparam int CW = cnt_width(WIDTH);

  logic             busy;
  logic             div_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi, lo, opnd;
  logic [WIDTH-1:0] hi_n, lo_n, rem_sub;
  logic [WIDTH:0]   add_sum, shifted;

  assign done     = busy && (cnt == CW'(WIDTH - 1));
  assign hilo_nxt = {hi_n, lo_n};

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    hi_n    = hi;
    lo_n    = lo;
    add_sum = '0;
    shifted = {hi, lo[WIDTH-1]};
    rem_sub = shifted[WIDTH-1:0] - opnd;
    if (div_q) begin
      // Remainder < divisor, so the low WIDTH bits of the trial difference are exact.
      if (shifted >= {1'b0, opnd}) begin
        hi_n = rem_sub;
        lo_n = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_n = shifted[WIDTH-1:0];
        lo_n = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      add_sum      = lo[0] ? ({1'b0, hi} + {1'b0, opnd}) : {1'b0, hi};
      {hi_n, lo_n} = {add_sum, lo[WIDTH-1:1]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      busy  <= 1'b0;
      div_q <= 1'b0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      opnd  <= '0;
    end else if (clear) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      div_q <= is_div;
      cnt   <= '0;
      hi    <= '0;
      lo    <= is_div ? a : b;
      opnd  <= is_div ? b : a;
    end else if (busy) begin
      hi <= hi_n;
      lo <= lo_n;
      if (done) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops resolve on accept, MUL/DIV iterate in
// iter_muldiv. Results and flags are held in output registers until taken.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  alu_op_e            op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               neg,
  output logic               zero,
  output logic               div_by_zero,
  output logic               gt,
  output logic               eq,
  output logic               lt
);

  state_e             state;
  logic [2*WIDTH-1:0] result_q, sc_result, md_nxt;
  alu_flags_t         flags_q, sc_flags;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   diff;
  logic               accept, is_iter, md_done;

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign is_iter  = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));

  always_comb begin
    sc_result      = '0;
    sc_flags       = '0;
    sum            = {1'b0, a} + {1'b0, b};
    diff           = (b > a) ? (b - a) : (a - b);
    sc_flags.gt    = a > b;
    sc_flags.eq    = a == b;
    sc_flags.lt    = a < b;
    case (op)
      OP_ADD: begin
        sc_result[WIDTH-1:0] = sum[WIDTH-1:0];
        sc_flags.carry       = sum[WIDTH];
      end
      OP_SUB: begin
        sc_result[WIDTH-1:0] = diff;
        sc_flags.neg         = b > a;
      end
      OP_AND: sc_result[WIDTH-1:0] = a & b;
      OP_OR:  sc_result[WIDTH-1:0] = a | b;
      OP_XOR: sc_result[WIDTH-1:0] = a ^ b;
      OP_CMP: sc_result[2:0] = {sc_flags.gt, sc_flags.eq, sc_flags.lt};
      OP_DIV: begin
        if (b == '0) begin
          sc_result            = {a, {WIDTH{1'b1}}};
          sc_flags.div_by_zero = 1'b1;
        end
      end
      default: ;  // MUL and DIV by non-zero finish in iter_muldiv
    endcase
    sc_flags.zero = (sc_result == '0);
  end

  iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .arst_n   (arst_n),
    .clear    (flush),
    .start    (accept && is_iter && !flush),
    .is_div   (op == OP_DIV),
    .a        (a),
    .b        (b),
    .done     (md_done),
    .hilo_nxt (md_nxt)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result_q  <= '0;
      flags_q   <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            result_q <= sc_result;
            flags_q  <= sc_flags;
            if (is_iter) begin
              state     <= BUSY;
              out_valid <= 1'b0;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end else if ((state == DONE) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        BUSY: begin
          // gt/eq/lt were captured on accept; only result and zero come from the iteration.
          if (md_done) begin
            result_q      <= md_nxt;
            flags_q.zero  <= (md_nxt == '0);
            state         <= DONE;
            out_valid     <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign result      = result_q;
  assign carry       = flags_q.carry;
  assign neg         = flags_q.neg;
  assign zero        = flags_q.zero;
  assign div_by_zero = flags_q.div_by_zero;
  assign gt          = flags_q.gt;
  assign eq          = flags_q.eq;
  assign lt          = flags_q.lt;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes model results, monitor pops on out_valid.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic [2*W-1:0] result;
    logic carry, neg, zero, dbz, gt, eq, lt;
  } obs_t;

  typedef struct {
    obs_t obs;
    int   lat;
    int   acc;
  } ent_t;

  logic           clk = 1'b0;
  logic           arst_n, flush, in_valid, in_ready, out_valid, out_ready;
  alu_op_e        op;
  logic [W-1:0]   a, b;
  logic [2*W-1:0] result;
  logic           carry, neg, zero, div_by_zero, gt, eq, lt;
  logic           dir_ready, rnd_ready, bp_rand;

  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  ent_t sb[$];
  bit   head_seen = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rnd_ready <= 1'($urandom_range(0, 1));
  assign out_ready = bp_rand ? rnd_ready : dir_ready;

  alu_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .carry       (carry),
    .neg         (neg),
    .zero        (zero),
    .div_by_zero (div_by_zero),
    .gt          (gt),
    .eq          (eq),
    .lt          (lt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model straight from the opcode definitions, using wide integer arithmetic.
  function automatic obs_t model(input alu_op_e o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint unsigned xa = x, yb = y, r = 0, m = (64'd1 << W) - 1;
    obs_t e = '0;
    e.gt = xa > yb;
    e.eq = xa == yb;
    e.lt = xa < yb;
    case (o)
      OP_ADD: begin r = (xa + yb) & m; e.carry = ((xa + yb) >> W) != 0; end
      OP_SUB: begin r = (xa >= yb) ? xa - yb : yb - xa; e.neg = yb > xa; end
      OP_AND: r = xa & yb;
      OP_OR:  r = xa | yb;
      OP_XOR: r = xa ^ yb;
      OP_CMP: r = (xa > yb ? 4 : 0) + (xa == yb ? 2 : 0) + (xa < yb ? 1 : 0);
      OP_MUL: r = xa * yb;
      OP_DIV: begin
        if (yb == 0) begin r = (xa << W) | m; e.dbz = 1'b1; end
        else r = ((xa % yb) << W) | (xa / yb);
      end
      default: r = 0;
    endcase
    e.result = (2*W)'(r);
    e.zero   = (r == 0);
    return e;
  endfunction

  function automatic obs_t observed();
    obs_t o;
    o = {result, carry, neg, zero, div_by_zero, gt, eq, lt};
    return o;
  endfunction

  // Called at/just after a negedge; returns at the negedge following the accept edge.
  task automatic send(input alu_op_e o, input logic [W-1:0] x, input logic [W-1:0] y);
    ent_t e;
    bit   ok = 0;
    op = o; a = x; b = y; in_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      #1;
      if (in_ready) begin
        e.obs = model(o, x, y);
        e.lat = (o == OP_MUL || (o == OP_DIV && y != 0)) ? W + 1 : 1;
        e.acc = cyc + 1;
        sb.push_back(e);
        ok = 1;
      end
      @(negedge clk);
    end
    check("send_accepted", 64'(ok), 64'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    op = alu_op_e'($urandom_range(0, 7));
    a  = W'($urandom);
    b  = W'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic drop_pending();
    sb.delete();
    head_seen = 0;
  endtask

  // Monitor: compares the head entry on every out_valid cycle, pops on handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (arst_n && out_valid) begin
        check("out_valid_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          if (!head_seen) begin
            check("latency", 64'(cyc - sb[0].acc + 1), 64'(sb[0].lat));
            head_seen = 1;
          end
          check("result_flags", 64'(observed()), 64'(sb[0].obs));
          if (out_ready) begin
            void'(sb.pop_front());
            head_seen = 0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int start;
    arst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; op = OP_ADD; a = '0; b = '0;
    dir_ready = 1'b1; bp_rand = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result_flags", 64'(observed()), 64'd0);
    @(negedge clk);
    arst_n = 1'b1;
    #1 check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Single-cycle ops back to back: one accept per cycle.
    start = cyc;
    send(OP_ADD, 8'd200, 8'd100);
    send(OP_SUB, 8'd3, 8'd10);
    send(OP_CMP, 8'h55, 8'h55);
    check("throughput_cycles", 64'(cyc - start), 64'd3);
    idle();
    drain();

    // MUL: in_ready low for the whole iteration.
    send(OP_MUL, 8'd255, 8'd255);
    idle();
    for (int i = 0; i < W; i++) begin
      #1 check("busy_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    drain();
    send(OP_DIV, 8'd100, 8'd7);
    idle();
    drain();
    send(OP_DIV, 8'd9, 8'd0);
    idle();
    drain();

    // Backpressure: held result, then same-cycle accept on release.
    dir_ready = 1'b0;
    send(OP_MUL, 8'd13, 8'd11);
    idle();
    for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
    repeat (5) begin
      #1;
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    dir_ready = 1'b1;
    start = cyc;
    send(OP_XOR, 8'hF0, 8'h3C);
    check("release_accept_cycles", 64'(cyc - start), 64'd1);
    idle();
    drain();

    // Flush mid-DIV: aborted op never reports.
    send(OP_DIV, 8'd100, 8'd7);
    idle();
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    drop_pending();
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    repeat (W + 2) @(negedge clk);
    send(OP_ADD, 8'd1, 8'd1);
    idle();
    drain();

    // Async reset mid-MUL.
    send(OP_MUL, 8'd200, 8'd3);
    idle();
    repeat (3) @(negedge clk);
    #3 arst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_result_flags", 64'(observed()), 64'd0);
    drop_pending();
    @(negedge clk);
    arst_n = 1'b1;
    repeat (W + 2) @(negedge clk);
    send(OP_ADD, 8'd1, 8'd1);
    idle();
    drain();

    // Randomized traffic with random backpressure.
    bp_rand = 1'b1;
    for (int n = 0; n < 300; n++) begin
      alu_op_e      ro;
      logic [W-1:0] ra, rb;
      ro = alu_op_e'($urandom_range(0, 7));
      ra = W'($urandom);
      rb = W'($urandom);
      if (ro == OP_DIV && $urandom_range(0, 3) == 0) rb = '0;
      if ($urandom_range(0, 3) == 0) begin
        idle();
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
      send(ro, ra, rb);
    end
    idle();
    drain();
    bp_rand = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
